ch_config_sequencer: RTL and testbench

Serializes multi-byte channel configuration writes from two requesters onto the channel's byte-wide config write port (CH_CONFIG_WE / CH_CONFIG_ADDR / CH_CONFIG_DATA). Requester A is the host command decoder; requester B is the sweep/PRBS update engine. Arbitration is round-robin. A load-protect interlock stops any write from re-enabling the channel output while protection is latched.

---
 rtl/ch_config_sequencer_if.sv | 51 +++++
 rtl/ch_config_sequencer.sv | 178 +++++++++++++++++
 tb/tb_ch_config_sequencer.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ch_config_sequencer_if.sv
// ch_config_sequencer_if
// Groups the signals of ch_config_sequencer other than the clock and reset:
//   - the two requester ports (A = host command decoder, B = sweep/PRBS engine):
//     req/addr/data/len in, ack/done out;
//   - the load-protect status input;
//   - the byte-wide channel config write port (WE/ADDR/DATA);
//   - the busy and blocked_cnt status outputs.
// slave  : the sequencer side.
// master : the side that drives the requests and consumes the write port.
interface ch_config_sequencer_if;
  logic        a_req;
  logic [7:0]  a_addr;
  logic [31:0] a_data;
  logic [1:0]  a_len;
  logic        a_ack;
  logic        a_done;

  logic        b_req;
  logic [7:0]  b_addr;
  logic [31:0] b_data;
  logic [1:0]  b_len;
  logic        b_ack;
  logic        b_done;

  logic        CH_LOAD_PROTECT_STATE;

  logic        CH_CONFIG_WE;
  logic [7:0]  CH_CONFIG_ADDR;
  logic [7:0]  CH_CONFIG_DATA;

  logic        busy;
  logic [7:0]  blocked_cnt;

  modport slave (
    input  a_req, a_addr, a_data, a_len,
    input  b_req, b_addr, b_data, b_len,
    input  CH_LOAD_PROTECT_STATE,
    output a_ack, a_done, b_ack, b_done,
    output CH_CONFIG_WE, CH_CONFIG_ADDR, CH_CONFIG_DATA,
    output busy, blocked_cnt
  );

  modport master (
    output a_req, a_addr, a_data, a_len,
    output b_req, b_addr, b_data, b_len,
    output CH_LOAD_PROTECT_STATE,
    input  a_ack, a_done, b_ack, b_done,
    input  CH_CONFIG_WE, CH_CONFIG_ADDR, CH_CONFIG_DATA,
    input  busy, blocked_cnt
  );
endinterface

// File: rtl/ch_config_sequencer.sv
// ch_config_sequencer
// Serializes 1..4-byte configuration writes from two requesters (A, B) onto a
// byte-wide channel config write port. Round-robin arbitration between A and B.
// A load-protect interlock clears DATA[0] of any byte written to ON_OFF_ADDR
// while CH_LOAD_PROTECT_STATE is set, and counts such writes (saturating).
//
// Parameters:
//   GAP_CYCLES  : WE-low cycles between consecutive bytes of one transaction (0..15)
//   ON_OFF_ADDR : address of the channel on/off byte guarded by the interlock
// Ports:
//   CLK_LOW : clock, all logic on its rising edge
//   reset_n : synchronous active-low reset
//   bus     : requester ports, protect input, write port, status (slave modport)
//
// All outputs are registered. The grant edge also issues byte 0, so ack and the
// first WE appear in the same cycle; done is registered together with the last byte.
module ch_config_sequencer #(
  parameter int          GAP_CYCLES  = 0,
  parameter logic [7:0]  ON_OFF_ADDR = 8'h2D
) (
  input  logic                   CLK_LOW,
  input  logic                   reset_n,
  ch_config_sequencer_if.slave   bus
);

  localparam logic [3:0] GAP_W = 4'(GAP_CYCLES);

  typedef enum logic [1:0] {IDLE, ISSUE, GAP} state_e;

  state_e      state_q;
  logic        rr_q;        // 0: A has priority on a tie, 1: B
  logic        sel_q;       // requester owning the current transaction (1 = B)
  logic [7:0]  base_q;
  logic [31:0] data_q;
  logic [1:0]  len_q;
  logic [1:0]  idx_q;       // index of the byte most recently issued
  logic [3:0]  gap_q;

  logic        we_q;
  logic [7:0]  addr_q;
  logic [7:0]  wdata_q;
  logic        a_ack_q, b_ack_q, a_done_q, b_done_q;
  logic        busy_q;
  logic [7:0]  blocked_q;

  // Byte-issue datapath: in IDLE the byte comes straight from the granted
  // requester's inputs (byte 0), otherwise from the working registers.
  logic        grant_any;
  logic        grant_b;
  logic        issue_en;
  logic        iss_sel;
  logic [1:0]  iss_idx;
  logic [1:0]  iss_len;
  logic [7:0]  iss_base;
  logic [31:0] iss_src;
  logic [7:0]  iss_addr;
  logic [7:0]  iss_raw;
  logic        iss_block;
  logic [7:0]  iss_byte;
  logic        iss_last;

  always_comb begin
    // NOTE: every signal written here gets a default first so no latch is inferred.
    grant_any = bus.a_req | bus.b_req;
    grant_b   = bus.b_req & (~bus.a_req | rr_q);
    issue_en  = 1'b0;
    iss_sel   = sel_q;
    iss_idx   = idx_q + 2'd1;
    iss_len   = len_q;
    iss_base  = base_q;
    iss_src   = data_q;

    unique case (state_q)
      IDLE: begin
        issue_en = grant_any;
        iss_sel  = grant_b;
        iss_idx  = 2'd0;
        iss_len  = grant_b ? bus.b_len  : bus.a_len;
        iss_base = grant_b ? bus.b_addr : bus.a_addr;
        iss_src  = grant_b ? bus.b_data : bus.a_data;
      end
      ISSUE:   issue_en = (idx_q != len_q) && (GAP_W == 4'd0);
      GAP:     issue_en = (gap_q == 4'd1);
      default: issue_en = 1'b0;
    endcase

    iss_addr  = iss_base + {6'd0, iss_idx};   // wraps 8'hFF -> 8'h00
    iss_raw   = iss_src[{iss_idx, 3'b000} +: 8];
    iss_block = bus.CH_LOAD_PROTECT_STATE && (iss_addr == ON_OFF_ADDR) && iss_raw[0];
    iss_byte  = {iss_raw[7:1], iss_raw[0] & ~iss_block};
    iss_last  = (iss_idx == iss_len);
  end

  always_ff @(posedge CLK_LOW) begin
    if (!reset_n) begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // register samples the pre-edge values regardless of statement order.
      state_q   <= IDLE;
      rr_q      <= 1'b0;
      sel_q     <= 1'b0;
      base_q    <= '0;
      data_q    <= '0;
      len_q     <= '0;
      idx_q     <= '0;
      gap_q     <= '0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      a_ack_q   <= 1'b0;
      b_ack_q   <= 1'b0;
      a_done_q  <= 1'b0;
      b_done_q  <= 1'b0;
      busy_q    <= 1'b0;
      blocked_q <= '0;
    end else begin
      // Pulses and the write strobe default low; ADDR/DATA read 0 when WE is low.
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      a_ack_q  <= 1'b0;
      b_ack_q  <= 1'b0;
      a_done_q <= 1'b0;
      b_done_q <= 1'b0;

      unique case (state_q)
        IDLE: begin
          if (grant_any) begin
            sel_q   <= grant_b;
            rr_q    <= ~grant_b;
            base_q  <= iss_base;
            data_q  <= iss_src;
            len_q   <= iss_len;
            a_ack_q <= ~grant_b;
            b_ack_q <= grant_b;
            busy_q  <= 1'b1;
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          if (idx_q == len_q) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else if (GAP_W != 4'd0) begin
            gap_q   <= GAP_W;
            state_q <= GAP;
          end
        end
        GAP: begin
          // Counter holds the remaining WE-low cycles including the current one.
          if (gap_q == 4'd1) state_q <= ISSUE;
          else               gap_q   <= gap_q - 4'd1;
        end
        default: state_q <= IDLE;
      endcase

      if (issue_en) begin
        we_q     <= 1'b1;
        addr_q   <= iss_addr;
        wdata_q  <= iss_byte;
        idx_q    <= iss_idx;
        a_done_q <= iss_last & ~iss_sel;
        b_done_q <= iss_last & iss_sel;
        if (iss_block && (blocked_q != 8'hFF)) blocked_q <= blocked_q + 8'd1;
      end
    end
  end

  assign bus.CH_CONFIG_WE   = we_q;
  assign bus.CH_CONFIG_ADDR = addr_q;
  assign bus.CH_CONFIG_DATA = wdata_q;
  assign bus.a_ack          = a_ack_q;
  assign bus.b_ack          = b_ack_q;
  assign bus.a_done         = a_done_q;
  assign bus.b_done         = b_done_q;
  assign bus.busy           = busy_q;
  assign bus.blocked_cnt    = blocked_q;

endmodule

// File: tb/tb_ch_config_sequencer.sv
// Bench for ch_config_sequencer: two instances (GAP_CYCLES=0 and GAP_CYCLES=2)
// sharing clock and reset. Inputs are driven and outputs sampled on the falling edge.
module tb_ch_config_sequencer;

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] data;
    logic [1:0]  len;
  } req_t;

  typedef struct {
    logic a_req;
    req_t a;
    logic b_req;
    req_t b;
    logic prot;
  } drv_t;

  typedef struct {
    logic       we;
    logic [7:0] addr;
    logic [7:0] data;
    logic       busy;
    logic [1:0] ack;   // {b, a}
    logic [1:0] done;  // {b, a}
    logic [7:0] blk;
  } obs_t;

  typedef struct {
    int   d;
    bit   ha;
    req_t ra;
    bit   hb;
    req_t rb;
    bit   prot;
    int   exp_first;
    int   exp_blk;
  } vec_t;

  logic CLK_LOW = 1'b0;
  logic reset_n = 1'b0;
  always #5 CLK_LOW = ~CLK_LOW;

  drv_t drv [2];
  int   gap_of [2] = '{0, 2};
  int   rr_m [2];     // model: requester favoured on a tie (0 = A)
  int   blk_m [2];    // model: blocked write count
  int   checks = 0;
  int   failures = 0;

  ch_config_sequencer_if ifc0 ();
  ch_config_sequencer_if ifc2 ();

  assign ifc0.a_req  = drv[0].a_req;      assign ifc2.a_req  = drv[1].a_req;
  assign ifc0.a_addr = drv[0].a.addr;     assign ifc2.a_addr = drv[1].a.addr;
  assign ifc0.a_data = drv[0].a.data;     assign ifc2.a_data = drv[1].a.data;
  assign ifc0.a_len  = drv[0].a.len;      assign ifc2.a_len  = drv[1].a.len;
  assign ifc0.b_req  = drv[0].b_req;      assign ifc2.b_req  = drv[1].b_req;
  assign ifc0.b_addr = drv[0].b.addr;     assign ifc2.b_addr = drv[1].b.addr;
  assign ifc0.b_data = drv[0].b.data;     assign ifc2.b_data = drv[1].b.data;
  assign ifc0.b_len  = drv[0].b.len;      assign ifc2.b_len  = drv[1].b.len;
  assign ifc0.CH_LOAD_PROTECT_STATE = drv[0].prot;
  assign ifc2.CH_LOAD_PROTECT_STATE = drv[1].prot;

  ch_config_sequencer #(.GAP_CYCLES(0), .ON_OFF_ADDR(8'h2D)) u_dut0 (
    .CLK_LOW (CLK_LOW),
    .reset_n (reset_n),
    .bus     (ifc0.slave)
  );

  ch_config_sequencer #(.GAP_CYCLES(2), .ON_OFF_ADDR(8'h2D)) u_dut2 (
    .CLK_LOW (CLK_LOW),
    .reset_n (reset_n),
    .bus     (ifc2.slave)
  );

  function automatic obs_t rd(input int d);
    obs_t o;
    if (d == 0) begin
      o.we = ifc0.CH_CONFIG_WE; o.addr = ifc0.CH_CONFIG_ADDR; o.data = ifc0.CH_CONFIG_DATA;
      o.busy = ifc0.busy; o.ack = {ifc0.b_ack, ifc0.a_ack};
      o.done = {ifc0.b_done, ifc0.a_done}; o.blk = ifc0.blocked_cnt;
    end else begin
      o.we = ifc2.CH_CONFIG_WE; o.addr = ifc2.CH_CONFIG_ADDR; o.data = ifc2.CH_CONFIG_DATA;
      o.busy = ifc2.busy; o.ack = {ifc2.b_ack, ifc2.a_ack};
      o.done = {ifc2.b_done, ifc2.a_done}; o.blk = ifc2.blocked_cnt;
    end
    return o;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference for one byte: address base+k (mod 256), byte k of the payload, and
  // DATA[0] cleared when protect is set and the byte would switch 8'h2D on.
  function automatic logic [15:0] model_byte(input req_t r, input int k, input bit prot,
                                             output bit blocked);
    logic [7:0]  a;
    logic [7:0]  v;
    logic [31:0] sh;
    a  = r.addr + 8'(k);
    sh = r.data >> (8 * k);
    v  = sh[7:0];
    blocked = prot && (a == 8'h2D) && v[0];
    if (blocked) v[0] = 1'b0;
    return {a, v};
  endfunction

  task automatic drop_req(input int d, input int g);
    if (g == 0) drv[d].a_req = 1'b0;
    else        drv[d].b_req = 1'b0;
  endtask

  // Presents the requests (starting right after a falling edge, DUT idle), then
  // follows every resulting transaction cycle by cycle against the model.
  task automatic run_txn(input int d, input bit ha, input req_t ra, input bit hb,
                         input req_t rb, input bit prot, output int first);
    bit         pend [2];
    req_t       rq [2];
    int         g;
    int         lat;
    bit         got;
    bit         blk;
    obs_t       o;
    logic [15:0] eb;
    logic [1:0]  gvec;
    pend = '{ha, hb};
    rq   = '{ra, rb};
    first = -1;
    drv[d].prot  = prot;
    drv[d].a     = ra;
    drv[d].b     = rb;
    drv[d].a_req = ha;
    drv[d].b_req = hb;
    while (pend[0] || pend[1]) begin
      g    = (pend[0] && pend[1]) ? rr_m[d] : (pend[0] ? 0 : 1);
      gvec = (g == 1) ? 2'b10 : 2'b01;
      lat  = 0;
      got  = 1'b0;
      for (int c = 0; c < 8 && !got; c++) begin
        @(negedge CLK_LOW);
        lat++;
        o   = rd(d);
        got = |o.ack;
      end
      check("ack_latency", 64'(lat), 64'd1);
      if (!got) begin
        drv[d].a_req = 1'b0;
        drv[d].b_req = 1'b0;
        break;
      end
      if (first < 0) first = g;
      drop_req(d, g);
      pend[g] = 1'b0;
      rr_m[d] = 1 - g;
      for (int k = 0; k <= int'(rq[g].len); k++) begin
        if (k > 0) begin
          for (int j = 0; j < gap_of[d]; j++) begin
            @(negedge CLK_LOW);
            o = rd(d);
            check("gap_we_busy", {o.we, o.busy, o.done}, {1'b0, 1'b1, 2'b00});
          end
          @(negedge CLK_LOW);
          o = rd(d);
        end
        eb = model_byte(rq[g], k, prot, blk);
        if (blk && blk_m[d] < 255) blk_m[d]++;
        check("byte_we_addr_data_busy_ack",
              {o.we, o.addr, o.data, o.busy, o.ack},
              {1'b1, eb, 1'b1, (k == 0) ? gvec : 2'b00});
        check("done", o.done, (k == int'(rq[g].len)) ? gvec : 2'b00);
      end
      @(negedge CLK_LOW);
      o = rd(d);
      check("post_idle", {o.we, o.busy, o.ack, o.done}, '0);
    end
    check("blocked_cnt", o.blk, 64'(blk_m[d]));
  endtask

  vec_t vt [9];

  initial begin
    obs_t o;
    int   first;
    req_t ra;
    req_t rb;
    req_t nil;
    nil = '{8'h00, 32'h0, 2'd0};
    for (int d = 0; d < 2; d++) begin
      drv[d] = '{1'b0, nil, 1'b0, nil, 1'b0};
      rr_m[d] = 0;
      blk_m[d] = 0;
    end

    // Reset state
    reset_n = 1'b0;
    repeat (3) @(negedge CLK_LOW);
    for (int d = 0; d < 2; d++) begin
      o = rd(d);
      check("reset_outputs", {o.we, o.addr, o.data, o.busy, o.ack, o.done, o.blk}, '0);
    end
    reset_n = 1'b1;
    @(negedge CLK_LOW);

    // Directed table: expected first grantee and blocked_cnt derived by hand.
    vt[0] = '{0, 1, '{8'h01, 32'hDEADBEEF, 2'd3}, 0, nil, 0, 0, 0};
    vt[1] = '{1, 1, '{8'h10, 32'h44332211, 2'd1}, 1, '{8'h20, 32'h88776655, 2'd0}, 0, 0, 0};
    vt[2] = '{0, 1, '{8'h30, 32'h000000AA, 2'd0}, 1, '{8'h40, 32'h0000BBCC, 2'd1}, 0, 1, 0};
    vt[3] = '{1, 0, nil, 1, '{8'hFE, 32'h00332211, 2'd2}, 0, 1, 0};
    vt[4] = '{0, 1, '{8'h2D, 32'h00000003, 2'd0}, 0, nil, 1, 0, 1};
    vt[5] = '{0, 1, '{8'h2C, 32'h00FF0301, 2'd2}, 0, nil, 1, 0, 2};
    vt[6] = '{0, 1, '{8'h2D, 32'h00000002, 2'd0}, 0, nil, 1, 0, 2};
    vt[7] = '{0, 1, '{8'h2D, 32'h00000003, 2'd0}, 0, nil, 0, 0, 2};
    vt[8] = '{1, 1, '{8'h2D, 32'h00000001, 2'd0}, 0, nil, 1, 0, 1};
    for (int i = 0; i < 9; i++) begin
      run_txn(vt[i].d, vt[i].ha, vt[i].ra, vt[i].hb, vt[i].rb, vt[i].prot, first);
      o = rd(vt[i].d);
      check($sformatf("tbl%0d_first", i), 64'(first), 64'(vt[i].exp_first));
      check($sformatf("tbl%0d_blocked", i), o.blk, 64'(vt[i].exp_blk));
    end

    // Saturation of the blocked counter.
    ra = '{8'h2D, 32'h00000001, 2'd0};
    for (int i = 0; i < 300; i++) run_txn(0, 1, ra, 0, nil, 1, first);
    o = rd(0);
    check("blocked_saturated", o.blk, 64'd255);
    run_txn(0, 1, '{8'h2D, 32'h00000003, 2'd0}, 0, nil, 0, first);
    o = rd(0);
    check("blocked_unchanged_unprotected", o.blk, 64'd255);

    // Randomized traffic against the model.
    for (int it = 0; it < 60; it++) begin
      int d;
      bit ha;
      bit hb;
      bit pr;
      d  = int'($urandom_range(0, 1));
      ha = 1'($urandom_range(0, 1));
      hb = ha ? 1'($urandom_range(0, 1)) : 1'b1;
      pr = 1'($urandom_range(0, 1));
      ra = '{8'($urandom), $urandom, 2'($urandom)};
      rb = '{8'($urandom), $urandom, 2'($urandom)};
      if ($urandom_range(0, 2) == 0) ra.addr = 8'h2B + 8'($urandom_range(0, 2));
      if ($urandom_range(0, 2) == 0) rb.addr = 8'h2D;
      run_txn(d, ha, ra, hb, rb, pr, first);
    end

    // Reset during the second byte of a 4-byte transaction.
    drv[0].prot  = 1'b0;
    drv[0].a     = '{8'h50, 32'h44332211, 2'd3};
    drv[0].a_req = 1'b1;
    @(negedge CLK_LOW);
    o = rd(0);
    check("mid_reset_ack", {o.ack, o.we, o.addr, o.data}, {2'b01, 1'b1, 8'h50, 8'h11});
    drv[0].a_req = 1'b0;
    @(negedge CLK_LOW);
    o = rd(0);
    check("mid_reset_byte1", {o.we, o.addr, o.data, o.done}, {1'b1, 8'h51, 8'h22, 2'b00});
    reset_n = 1'b0;
    @(negedge CLK_LOW);
    reset_n = 1'b1;
    for (int d = 0; d < 2; d++) begin
      o = rd(d);
      check("after_reset", {o.we, o.busy, o.ack, o.done, o.blk}, '0);
      rr_m[d]  = 0;
      blk_m[d] = 0;
    end
    for (int c = 0; c < 4; c++) begin
      @(negedge CLK_LOW);
      o = rd(0);
      check("abandoned_no_done", {o.we, o.busy, o.done}, '0);
    end
    run_txn(0, 1, '{8'h60, 32'h000000A5, 2'd0}, 1, '{8'h70, 32'h0000005A, 2'd0}, 0, first);
    check("rr_after_reset", 64'(first), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
